// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, optional 2-entry skid,
// flush-driven bubble insertion and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W   = 147,
  parameter int CTRL_W   = 7,
  parameter int SKID     = 1,
  parameter int NEG_EDGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              clk_act;
  logic              m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, drain;

  assign clk_act = (NEG_EDGE != 0) ? ~clk : clk;

  assign in_ready  = (SKID != 0) ? ~s_vld_q : (~m_vld_q | out_ready);
  assign out_valid = m_vld_q;
  // Bubbles must never carry live write enables downstream.
  assign out_ctrl  = m_vld_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign stall_cnt = cnt_q;

  assign accept = in_valid & in_ready;
  assign drain  = m_vld_q & out_ready;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    cnt_d    = cnt_q;

    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (SKID != 0) begin
      if (!m_vld_q || (drain && !s_vld_q)) begin
        m_vld_d = accept;
        if (accept) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end
      end else if (drain) begin
        // Skid full implies in_ready=0, so only the promotion happens here.
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        s_vld_d  = 1'b0;
      end else if (accept) begin
        s_vld_d  = 1'b1;
        s_ctrl_d = in_ctrl;
        s_data_d = in_data;
      end
    end else begin
      if (accept) begin
        m_vld_d  = 1'b1;
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
      end else if (drain) begin
        m_vld_d = 1'b0;
      end
    end

    if (m_vld_q && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_act or posedge rst) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_vld_q  <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid/falling-edge instance (A) and a no-skid/rising-edge
// instance (B), each checked every cycle against a queue model plus directed literals.
module tb_pipe_stage_reg;

  localparam int DW = 147;
  localparam int CW = 7;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [3:0]    a_stall;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [3:0]    b_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .NEG_EDGE(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .NEG_EDGE(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall));

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity 2 (skid) or 1; head is what the stage presents.
  ent_t          qa[$];
  ent_t          qb[$];
  logic [DW-1:0] ma_data = '0;
  logic [DW-1:0] mb_data = '0;
  int            ma_cnt  = 0;
  int            mb_cnt  = 0;

  always @(negedge clk or posedge rst) begin : model_a
    bit rdy, acc, drn;
    ent_t e;
    if (rst) begin
      qa.delete(); ma_data = '0; ma_cnt = 0;
    end else begin
      rdy = qa.size() < 2;
      acc = a_in_valid && rdy;
      drn = (qa.size() != 0) && a_out_ready;
      if (qa.size() != 0 && !a_out_ready && !a_flush && ma_cnt != 15) ma_cnt++;
      if (a_flush) qa.delete();
      else begin
        if (drn) void'(qa.pop_front());
        if (acc) begin e.c = a_in_ctrl; e.d = a_in_data; qa.push_back(e); end
      end
      if (qa.size() != 0) ma_data = qa[0].d;
    end
  end

  always @(posedge clk or posedge rst) begin : model_b
    bit rdy, acc, drn;
    ent_t e;
    if (rst) begin
      qb.delete(); mb_data = '0; mb_cnt = 0;
    end else begin
      rdy = (qb.size() == 0) || b_out_ready;
      acc = b_in_valid && rdy;
      drn = (qb.size() != 0) && b_out_ready;
      if (qb.size() != 0 && !b_out_ready && !b_flush && mb_cnt != 15) mb_cnt++;
      if (b_flush) qb.delete();
      else begin
        if (drn) void'(qb.pop_front());
        if (acc) begin e.c = b_in_ctrl; e.d = b_in_data; qb.push_back(e); end
      end
      if (qb.size() != 0) mb_data = qb[0].d;
    end
  end

  always @(posedge clk) begin : cmp_a
    logic [CW-1:0] ec;
    ec = (qa.size() != 0) ? qa[0].c : '0;
    check("a_out_valid", a_out_valid, qa.size() != 0);
    check("a_out_ctrl", a_out_ctrl, ec);
    check("a_out_data", a_out_data, ma_data);
    check("a_in_ready", a_in_ready, qa.size() < 2);
    check("a_stall_cnt", a_stall, ma_cnt[3:0]);
  end

  always @(negedge clk) begin : cmp_b
    logic [CW-1:0] ec;
    ec = (qb.size() != 0) ? qb[0].c : '0;
    check("b_out_valid", b_out_valid, qb.size() != 0);
    check("b_out_ctrl", b_out_ctrl, ec);
    check("b_out_data", b_out_data, mb_data);
    check("b_in_ready", b_in_ready, (qb.size() == 0) || b_out_ready);
    check("b_stall_cnt", b_stall, mb_cnt[3:0]);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic offer_a(input logic [DW-1:0] d);
    a_in_valid = 1'b1; a_in_data = d; a_in_ctrl = d[CW-1:0];
  endtask

  task automatic offer_b(input logic [DW-1:0] d);
    b_in_valid = 1'b1; b_in_data = d; b_in_ctrl = d[CW-1:0];
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_ctrl = 7'h7F; a_in_data = 'hABC; a_out_ready = 1;
    b_flush = 0; b_in_valid = 0; b_in_ctrl = 0;     b_in_data = 0;     b_out_ready = 1;

    // Reset with a live offer
    cyc(); cyc();
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_ctrl", a_out_ctrl, 7'h00);
    check("rst_stall", a_stall, 4'd0);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    rst = 1'b0;
    cyc();
    check("rel_out_valid", a_out_valid, 1'b1);
    check("rel_out_ctrl", a_out_ctrl, 7'h7F);
    check("rel_out_data", a_out_data, 'hABC);

    // A: streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      offer_a(i);
      cyc();
      check("stream_data", a_out_data, i);
      check("stream_ready", a_in_ready, 1'b1);
    end
    a_in_valid = 0;
    cyc();
    check("stream_empty", a_out_valid, 1'b0);
    check("stream_hold_data", a_out_data, 4);

    // A: back-pressure fills main then skid
    a_out_ready = 0;
    offer_a('h0A); cyc();
    offer_a('h0B); cyc();
    check("bp_ready_low", a_in_ready, 1'b0);
    offer_a('h0C); cyc(); cyc();
    check("bp_head", a_out_data, 'h0A);
    check("bp_stall", a_stall, 4'd3);
    a_out_ready = 1;
    cyc();
    check("bp_second", a_out_data, 'h0B);
    cyc();
    check("bp_third", a_out_data, 'h0C);
    a_in_valid = 0;
    cyc();
    check("bp_drained", a_out_valid, 1'b0);
    check("bp_stall_kept", a_stall, 4'd3);

    // A: flush with full skid and an offer pending
    a_out_ready = 0;
    offer_a('h1A); cyc();
    offer_a('h1B); cyc();
    offer_a('h1C); a_flush = 1; cyc();
    check("fl_out_valid", a_out_valid, 1'b0);
    check("fl_out_ctrl", a_out_ctrl, 7'h00);
    check("fl_in_ready", a_in_ready, 1'b1);
    check("fl_data_hold", a_out_data, 'h1A);
    check("fl_stall", a_stall, 4'd4);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    cyc(); cyc();
    check("fl_nothing_out", a_out_valid, 1'b0);

    // A: saturation then mid-run reset
    a_out_ready = 0; offer_a('h55);
    for (int i = 0; i < 20; i++) cyc();
    check("sat_a", a_stall, 4'd15);
    cyc();
    check("sat_a_hold", a_stall, 4'd15);
    rst = 1; cyc();
    check("sat_a_rst", a_stall, 4'd0);
    check("sat_a_rst_valid", a_out_valid, 1'b0);
    rst = 0; a_in_valid = 0; a_out_ready = 1;
    cyc();

    // B: combinational ready
    b_out_ready = 0; offer_b('hD3);
    cyc();
    check("b_first", b_out_data, 'hD3);
    check("b_ready_low", b_in_ready, 1'b0);
    offer_b('hD5);
    cyc();
    check("b_held", b_out_data, 'hD3);
    check("b_stall1", b_stall, 4'd1);
    b_out_ready = 1;
    #1;
    check("b_ready_comb", b_in_ready, 1'b1);
    cyc();
    check("b_captured", b_out_data, 'hD5);
    check("b_captured_ctrl", b_out_ctrl, 7'h55);
    b_in_valid = 0;
    cyc();
    check("b_empty", b_out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      offer_b('h100 + i);
      cyc();
      check("b_stream", b_out_data, 'h100 + i);
    end
    offer_b('hEE); b_flush = 1;
    cyc();
    check("b_fl_valid", b_out_valid, 1'b0);
    check("b_fl_hold", b_out_data, 'h102);
    b_flush = 0;
    b_out_ready = 0; offer_b('h77);
    for (int i = 0; i < 20; i++) cyc();
    check("sat_b", b_stall, 4'd15);
    rst = 1; cyc();
    check("sat_b_rst", b_stall, 4'd0);
    rst = 0; b_in_valid = 0; b_out_ready = 1;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
